// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: 640x480 timing constants, frame-buffer geometry and read-tag type
package vga_fb_pkg;
  localparam int HD = 640;
  localparam int VD = 480;
  localparam int HT = 800;
  localparam int VT = 525;
  localparam int DW = 16;
  localparam int AW = 15;
  localparam int LDW = $clog2(DW);
  localparam int WPL = HD / DW;
  localparam int FB_WORDS = HD * VD / DW;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} tag_e;
endpackage

// File: rtl/vga_pix_shift.sv
// vga_pix_shift: DW-bit load/shift serialiser, MSB is the leftmost pixel
module vga_pix_shift
  import vga_fb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_blank,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  output logic          o_pix
);
  logic          r_pix;
  logic [DW-1:0] r_sh;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix <= 1'b0;
      r_sh  <= '0;
    end else begin
      r_pix <= i_blank ? 1'b0 : i_load ? i_data[DW-1] : r_sh[DW-1];
      r_sh  <= i_load ? i_data << 1 : r_sh << 1;
    end
  end
  assign o_pix = r_pix;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one sync frame-buffer RAM between display fetches and a host port
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic          clkP,
  input  logic          rst,
  input  logic [10:0]   pixelX,
  input  logic [9:0]    pixelY,
  input  logic          h_valid,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ready,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          pixel_out
);
  logic [9:0]    w_next_y;
  logic          w_fs, w_mid, w_g0, w_slot, w_acc, w_blank;
  logic [AW-1:0] r_disp_addr;
  logic          r_synced;
  tag_e          r_tag1, r_tag2;

  assign w_next_y = (pixelY == 10'(VT - 1)) ? 10'd0 : pixelY + 10'd1;
  assign w_fs  = (pixelX == 11'(HT - 2)) && (pixelY == 10'(VT - 1));
  // line slots run only once the frame counter has been aligned by a frame start
  assign w_mid = r_synced && (pixelX[LDW-1:0] == LDW'(DW - 2)) &&
                 (pixelX[10:LDW] < (11 - LDW)'(WPL - 1)) && (pixelY < 10'(VD));
  assign w_g0  = r_synced && (pixelX == 11'(HT - 2)) && (pixelY < 10'(VT)) && (w_next_y < 10'(VD));
  assign w_slot = w_fs || w_mid || w_g0;
  assign h_ready = !rst && !w_slot && (r_tag1 != TAG_HOST);
  assign w_acc = h_valid && h_ready;
  assign w_blank = !r_synced || (pixelX >= 11'(HD)) || (pixelY >= 10'(VD));

  always_ff @(posedge clkP) begin
    if (rst) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      r_disp_addr <= '0;
      r_synced    <= 1'b0;
      r_tag1      <= TAG_NONE;
      r_tag2      <= TAG_NONE;
      h_rvalid    <= 1'b0;
      h_rdata     <= '0;
    end else begin
      mem_en      <= w_slot || w_acc;
      mem_we      <= w_acc && h_we;
      mem_addr    <= w_fs ? '0 : w_slot ? r_disp_addr : w_acc ? h_addr : mem_addr;
      mem_wdata   <= (w_acc && h_we) ? h_wdata : mem_wdata;
      r_disp_addr <= w_fs ? AW'(1) : w_slot ? r_disp_addr + 1'b1 : r_disp_addr;
      r_synced    <= r_synced || w_fs;
      r_tag1      <= w_slot ? TAG_DISP : (w_acc && !h_we) ? TAG_HOST : TAG_NONE;
      r_tag2      <= r_tag1;
      h_rvalid    <= r_tag2 == TAG_HOST;
      h_rdata     <= (r_tag2 == TAG_HOST) ? mem_rdata : h_rdata;
    end
  end

  vga_pix_shift u_shift (
    .clk    (clkP),
    .rst    (rst),
    .i_blank(w_blank),
    .i_load (pixelX[LDW-1:0] == '0),
    .i_data (mem_rdata),
    .o_pix  (pixel_out)
  );
endmodule
